// File: rtl/imm_gen_if.sv
// Instruction-in / immediate-out handshake bundle for imm_gen_pipe.
// The slave modport is the decoder's view of the bundle.
// The master modport is the view of whoever drives instructions and consumes results.
interface imm_gen_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_inst;
  logic            in_signext;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_imm;
  logic [2:0]      out_fmt;
  logic            out_illegal;
  logic [31:0]     out_inst;

  modport slave (
    input  in_valid,
    input  in_inst,
    input  in_signext,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_imm,
    output out_fmt,
    output out_illegal,
    output out_inst
  );

  modport master (
    output in_valid,
    output in_inst,
    output in_signext,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_imm,
    input  out_fmt,
    input  out_illegal,
    input  out_inst
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: single-stage pipelined RISC-V immediate generator.
// It accepts one RV32/RV64 base instruction per cycle over a valid/ready handshake.
// It returns the decoded immediate, the format code and an illegal-opcode flag one cycle later.
// Optional feature: define IMM_GEN_ILLEGAL_CNT_EN to add the ill_cnt output.
// ill_cnt is a saturating count of accepted instructions with unsupported opcodes.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input logic      clk,
  input logic      rst,
  imm_gen_if.slave bus
`ifdef IMM_GEN_ILLEGAL_CNT_EN
  ,
  output logic [CNT_W-1:0] ill_cnt
`endif
);

  // Format codes carried on out_fmt
  typedef enum logic [2:0] {
    FMT_NONE  = 3'd0,
    FMT_I     = 3'd1,
    FMT_S     = 3'd2,
    FMT_B     = 3'd3,
    FMT_U     = 3'd4,
    FMT_J     = 3'd5,
    FMT_SHAMT = 3'd6,
    FMT_CSR   = 3'd7
  } fmt_e;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SRX = 3'b101;

  logic [31:0] inst;
  logic [6:0]  opcode;
  logic [2:0]  funct3;

  assign inst   = bus.in_inst;
  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];

  // Raw immediate fields, held as signed so that widening casts sign-extend
  logic signed [20:0] j_raw;
  logic signed [12:0] b_raw;
  logic signed [11:0] s_raw;
  logic signed [11:0] i_raw;
  logic signed [31:0] u_raw;

  assign j_raw = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  assign b_raw = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign s_raw = {inst[31:25], inst[11:7]};
  assign i_raw = inst[31:20];
  assign u_raw = {inst[31:12], 12'b0};

  // Immediates widened to XLEN
  logic [XLEN-1:0] j_imm;
  logic [XLEN-1:0] b_imm;
  logic [XLEN-1:0] s_imm;
  logic [XLEN-1:0] i_sext;
  logic [XLEN-1:0] i_zext;
  logic [XLEN-1:0] u_imm;
  logic [XLEN-1:0] shamt_imm;
  logic [XLEN-1:0] zimm;

  assign j_imm  = XLEN'(j_raw);
  assign b_imm  = XLEN'(b_raw);
  assign s_imm  = XLEN'(s_raw);
  assign i_sext = XLEN'(i_raw);
  assign i_zext = XLEN'(inst[31:20]);
  assign u_imm  = XLEN'(u_raw);
  assign zimm   = XLEN'(inst[19:15]);

  // RV64 shifts take a 6-bit shift amount; RV32 only 5 bits
  generate
    if (XLEN == 64) begin : g_shamt64
      assign shamt_imm = XLEN'(inst[25:20]);
    end else begin : g_shamt32
      assign shamt_imm = XLEN'(inst[24:20]);
    end
  endgenerate

  // Load/OP-IMM immediates follow in_signext; JALR always sign-extends
  logic [XLEN-1:0] i_sel;
  assign i_sel = bus.in_signext ? i_sext : i_zext;

  logic [XLEN-1:0] dec_imm;
  fmt_e            dec_fmt;
  logic            dec_illegal;

  // Opcode decode: choose the format and immediate for the incoming word
  always_comb begin
    dec_imm     = '0;
    dec_fmt     = FMT_NONE;
    dec_illegal = 1'b0;
    case (opcode)
      OP_JAL: begin
        dec_fmt = FMT_J;
        dec_imm = j_imm;
      end
      OP_BRANCH: begin
        dec_fmt = FMT_B;
        dec_imm = b_imm;
      end
      OP_STORE: begin
        dec_fmt = FMT_S;
        dec_imm = s_imm;
      end
      OP_LOAD: begin
        dec_fmt = FMT_I;
        dec_imm = i_sel;
      end
      OP_JALR: begin
        dec_fmt = FMT_I;
        dec_imm = i_sext;
      end
      OP_IMM: begin
        if (funct3 == F3_SLL || funct3 == F3_SRX) begin
          dec_fmt = FMT_SHAMT;
          dec_imm = shamt_imm;
        end else begin
          dec_fmt = FMT_I;
          dec_imm = i_sel;
        end
      end
      OP_LUI, OP_AUIPC: begin
        dec_fmt = FMT_U;
        dec_imm = u_imm;
      end
      OP_SYSTEM: begin
        dec_fmt = FMT_CSR;
        dec_imm = zimm;
      end
      OP_REG: begin
        dec_fmt = FMT_NONE;
        dec_imm = '0;
      end
      default: begin
        dec_fmt     = FMT_NONE;
        dec_imm     = '0;
        dec_illegal = 1'b1;
      end
    endcase
  end

  // Output register stage
  logic            out_valid_q;
  logic [XLEN-1:0] out_imm_q;
  fmt_e            out_fmt_q;
  logic            out_illegal_q;
  logic [31:0]     out_inst_q;

  logic in_ready_int;
  logic xfer;

  // The stage can take a new word whenever it is empty or its result leaves this cycle
  assign in_ready_int = !out_valid_q || bus.out_ready;
  assign xfer         = bus.in_valid && in_ready_int;

  // Load on transfer, drop valid when the result is popped with nothing behind it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q   <= 1'b0;
      out_imm_q     <= '0;
      out_fmt_q     <= FMT_NONE;
      out_illegal_q <= 1'b0;
      out_inst_q    <= '0;
    end else if (xfer) begin
      out_valid_q   <= 1'b1;
      out_imm_q     <= dec_imm;
      out_fmt_q     <= dec_fmt;
      out_illegal_q <= dec_illegal;
      out_inst_q    <= inst;
    end else if (bus.out_ready) begin
      out_valid_q   <= 1'b0;
    end
  end

  assign bus.in_ready    = in_ready_int;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_imm     = out_imm_q;
  assign bus.out_fmt     = out_fmt_q;
  assign bus.out_illegal = out_illegal_q;
  assign bus.out_inst    = out_inst_q;

`ifdef IMM_GEN_ILLEGAL_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] ill_cnt_q;

  // Count accepted unsupported opcodes, sticking at all-ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ill_cnt_q <= '0;
    end else if (xfer && dec_illegal && ill_cnt_q != CNT_MAX) begin
      ill_cnt_q <= ill_cnt_q + 1'b1;
    end
  end

  assign ill_cnt = ill_cnt_q;
`endif

endmodule
